// File: rtl/uart_tx_pkg.sv
// rtl/uart_tx_pkg.sv - shared state type and line levels for the UART transmit path
package uart_tx_pkg;

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      PARITY,
      STOP
   } tx_state_t;

   localparam logic LINE_IDLE = 1'b1;
   localparam logic START_BIT = 1'b0;

endpackage

// File: rtl/tx_bit_timer.sv
// rtl/tx_bit_timer.sv - up-counter that wraps to zero after a programmable rollover value
module tx_bit_timer
   import uart_tx_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             n_rst,
   input  logic             clear,
   input  logic             count_enable,
   input  logic [WIDTH-1:0] rollover_val,
   output logic [WIDTH-1:0] count,
   output logic             rollover_flag
);

   // Flag marks the enabled cycle on which the count wraps, i.e. the end of a period.
   assign rollover_flag = count_enable && (count == rollover_val);

   // Count enabled cycles, wrapping at rollover_val; clear restarts a fresh period.
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         count <= '0;
      end else if (clear) begin
         count <= '0;
      end else if (rollover_flag) begin
         count <= '0;
      end else if (count_enable) begin
         count <= count + 1'b1;
      end
   end

endmodule

// File: rtl/uart_tx_ctrl.sv
// rtl/uart_tx_ctrl.sv - UART transmit controller; define UART_TX_PARITY_EN to add an even-parity bit
module uart_tx_ctrl
   import uart_tx_pkg::*;
#(
   parameter int CLKS_PER_BIT = 10,
   parameter int DATA_BITS    = 8,
   parameter int STOP_BITS    = 1
) (
   input  logic       clk,
   input  logic       n_rst,
   input  logic       fifo_empty,
   input  logic [7:0] fifo_r_data,
   output logic       fifo_r_enable,
   output logic       tx_out,
   output logic       tx_busy
);

   localparam int TICK_W = 8;
   localparam int IDX_W  = 3;
   localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(CLKS_PER_BIT - 1);
   localparam logic [IDX_W-1:0]  DATA_LAST = IDX_W'(DATA_BITS - 1);
   localparam logic [IDX_W-1:0]  STOP_LAST = IDX_W'(STOP_BITS - 1);

   tx_state_t            state;
   logic [DATA_BITS-1:0] shift;
   logic [TICK_W-1:0]    tick_cnt;
   logic [IDX_W-1:0]     bit_idx;
   logic [IDX_W-1:0]     bit_limit;
   logic                 bit_end;
   logic                 bit_cnt_en;
   logic                 bit_limit_hit;
   logic                 last_stop;
   logic                 load;
   logic                 unused_counts;
`ifdef UART_TX_PARITY_EN
   logic                 parity_bit;
`endif

   // The index counter measures data bits in DATA and stop bits in STOP.
   assign bit_limit  = (state == STOP) ? STOP_LAST : DATA_LAST;
   assign bit_cnt_en = bit_end && ((state == DATA) || (state == STOP));
   assign last_stop  = (state == STOP) && bit_limit_hit;

   // A byte is taken when idle or on the very last stop cycle, giving zero-gap frames.
   // Gated by n_rst so no pop can be issued while the block is held in reset.
   assign load          = n_rst && !fifo_empty && ((state == IDLE) || last_stop);
   assign fifo_r_enable = load;

   // The running counts themselves are not needed; only their wrap events steer the FSM.
   assign unused_counts = ^{tick_cnt, bit_idx};

   tx_bit_timer #(
      .WIDTH(TICK_W)
   ) u_clk_timer (
      .clk          (clk),
      .n_rst        (n_rst),
      .clear        (load),
      .count_enable (state != IDLE),
      .rollover_val (TICK_LAST),
      .count        (tick_cnt),
      .rollover_flag(bit_end)
   );

   tx_bit_timer #(
      .WIDTH(IDX_W)
   ) u_bit_timer (
      .clk          (clk),
      .n_rst        (n_rst),
      .clear        (load),
      .count_enable (bit_cnt_en),
      .rollover_val (bit_limit),
      .count        (bit_idx),
      .rollover_flag(bit_limit_hit)
   );

   // Frame sequencer: loads a byte, then walks start, data, optional parity and stop bits.
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         state   <= IDLE;
         tx_out  <= LINE_IDLE;
         tx_busy <= 1'b0;
         shift   <= '0;
`ifdef UART_TX_PARITY_EN
         parity_bit <= 1'b0;
`endif
      end else if (load) begin
         state   <= START;
         shift   <= fifo_r_data[DATA_BITS-1:0];
         tx_out  <= START_BIT;
         tx_busy <= 1'b1;
`ifdef UART_TX_PARITY_EN
         parity_bit <= ^fifo_r_data[DATA_BITS-1:0];
`endif
      end else begin
         case (state)
            IDLE: begin
               tx_out <= LINE_IDLE;
            end
            START: begin
               if (bit_end) begin
                  state  <= DATA;
                  tx_out <= shift[0];
               end
            end
            DATA: begin
               if (bit_end) begin
                  if (bit_limit_hit) begin
`ifdef UART_TX_PARITY_EN
                     state  <= PARITY;
                     tx_out <= parity_bit;
`else
                     state  <= STOP;
                     tx_out <= LINE_IDLE;
`endif
                  end else begin
                     shift  <= shift >> 1;
                     tx_out <= shift[1];
                  end
               end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
               if (bit_end) begin
                  state  <= STOP;
                  tx_out <= LINE_IDLE;
               end
            end
`endif
            STOP: begin
               if (last_stop) begin
                  state   <= IDLE;
                  tx_busy <= 1'b0;
               end
            end
            default: begin
               state   <= IDLE;
               tx_out  <= LINE_IDLE;
               tx_busy <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// tb/tb_uart_tx_ctrl.sv - scoreboard bench for uart_tx_ctrl; follows UART_TX_PARITY_EN when defined
module tb_uart_tx_ctrl;

   localparam int C  = 10;
   localparam int DB = 8;
   localparam int SB = 1;
`ifdef UART_TX_PARITY_EN
   localparam int P  = 1;
`else
   localparam int P  = 0;
`endif
   localparam int NB = 1 + DB + P + SB;
   localparam int FL = NB * C;

   typedef struct {
      logic [11:0] bits;
      int          start;
   } exp_t;

   logic       clk = 1'b0;
   logic       n_rst = 1'b1;
   logic       fifo_empty = 1'b1;
   logic [7:0] fifo_r_data = 8'h00;
   logic       fifo_r_enable;
   logic       tx_out;
   logic       tx_busy;

   exp_t       exp_q[$];
   logic [7:0] fifo_q[$];
   int         next_free = 0;
   bit         done = 1'b0;
   int         cyc = 0;

   int         exp_rd = 0;
   int         pops = 0;
   int         cmp_cnt = 0;
   int         err_cnt = 0;
   bit         active = 1'b0;
   bit         rst_prev = 1'b1;
   int         fstart = 0;
   int         off = 0;
   exp_t       cur;

   uart_tx_ctrl #(
      .CLKS_PER_BIT(C),
      .DATA_BITS   (DB),
      .STOP_BITS   (SB)
   ) dut (
      .clk          (clk),
      .n_rst        (n_rst),
      .fifo_empty   (fifo_empty),
      .fifo_r_data  (fifo_r_data),
      .fifo_r_enable(fifo_r_enable),
      .tx_out       (tx_out),
      .tx_busy      (tx_busy)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Reference frame: start low, data LSB first, even parity if enabled, stop bits high.
   function automatic logic [11:0] frame_bits(input logic [7:0] b);
      logic [11:0] f;
      f = '1;
      f[0] = 1'b0;
      for (int i = 0; i < DB; i++) f[1 + i] = b[i];
      if (P == 1) f[1 + DB] = ^b[DB-1:0];
      return f;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      cmp_cnt++;
      if (act !== exp) begin
         err_cnt++;
         $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic drive_fifo();
      if (fifo_q.size() == 0) begin
         fifo_empty  = 1'b1;
         fifo_r_data = 8'($urandom);
      end else begin
         fifo_empty  = 1'b0;
         fifo_r_data = fifo_q[0];
      end
   endtask

   // One clock: note a pop while outputs are stable, then retire it after the edge.
   task automatic step();
      logic pop;
      @(negedge clk);
      pop = fifo_r_enable;
      @(posedge clk);
      #1;
      if (pop && fifo_q.size() > 0) void'(fifo_q.pop_front());
      drive_fifo();
   endtask

   task automatic wait_until(input int t);
      while (cyc < t) step();
   endtask

   // A byte becomes visible to the next edge; it starts then, or when the prior frame ends.
   task automatic push_byte(input logic [7:0] b);
      exp_t e;
      e.bits  = frame_bits(b);
      e.start = (cyc + 1 > next_free) ? cyc + 1 : next_free;
      next_free = e.start + FL;
      exp_q.push_back(e);
      fifo_q.push_back(b);
      drive_fifo();
   endtask

   task automatic glitch_empty();
      fifo_empty  = 1'b0;
      fifo_r_data = 8'($urandom);
      step();
   endtask

   // Monitor: receiver-style sampler that checks every frame against the scoreboard.
   always begin
      @(negedge clk or negedge n_rst);
      if (rst_prev && !n_rst) begin
         rst_prev = 1'b0;
         #1;
         chk("reset_tx_out", tx_out, 1);
         chk("reset_tx_busy", tx_busy, 0);
         chk("reset_pop", fifo_r_enable, 0);
         active = 1'b0;
         exp_rd = exp_q.size();
      end else if (!n_rst) begin
         active = 1'b0;
         exp_rd = exp_q.size();
      end else begin
         rst_prev = 1'b1;
         if (done) begin
            chk("drained", exp_rd, exp_q.size());
            chk("pop_count", pops, exp_q.size());
            chk("final_tx_out", tx_out, 1);
            chk("final_tx_busy", tx_busy, 0);
            $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
            $finish;
         end
         if (fifo_r_enable) begin
            pops++;
            chk("pop_while_empty", fifo_empty, 0);
         end
         if (!active && tx_out == 1'b0) begin
            if (exp_rd < exp_q.size()) begin
               cur    = exp_q[exp_rd];
               exp_rd++;
               active = 1'b1;
               fstart = cyc;
               chk("frame_start", cyc, cur.start);
            end else begin
               chk("unexpected_start", tx_out, 1);
            end
         end
         chk("tx_busy", tx_busy, active);
         if (active) begin
            off = cyc - fstart;
            if (off % C == C / 2)
               chk($sformatf("frame%0d_bit%0d", exp_rd - 1, off / C), tx_out, cur.bits[off / C]);
            if (off == FL - 1) active = 1'b0;
         end
      end
   end

   // Stimulus: directed scenarios first, then randomized bytes and gaps.
   initial begin
      int s;
      #2 n_rst = 1'b0;
      repeat (3) step();
      n_rst = 1'b1;
      repeat (100) step();

      push_byte(8'hA5);
      wait_until(next_free - FL + 50);
      glitch_empty();
      wait_until(next_free + 5);

      push_byte(8'h07);
      wait_until(next_free + 3);

      push_byte(8'h55);
      push_byte(8'hAA);
      wait_until(next_free + 5);

      push_byte(8'h3C);
      wait_until(next_free - 1);
      push_byte(8'hC3);
      wait_until(next_free - 1 - $urandom_range(1, 8));
      push_byte(8'h81);
      wait_until(next_free + 5);

      push_byte(8'hF0);
      s = next_free - FL;
      wait_until(s + 43);
      #2 n_rst = 1'b0;
      step();
      step();
      n_rst = 1'b1;
      next_free = 0;
      repeat (60) step();

      repeat (60) begin
         push_byte(8'($urandom));
         if ($urandom_range(0, 3) != 0) repeat ($urandom_range(0, 2 * FL)) step();
      end
      wait_until(next_free + 20);

      done = 1'b1;
      repeat (5) step();
      $display("FAIL watchdog: monitor never closed the run (cycle %0d)", cyc);
      $fatal(1, "watchdog");
   end

endmodule
